// File: rtl/interrupt_controller.sv
// interrupt_controller: N-source active-low IRQ unit with level/edge sampling, masking,
// fixed lowest-index priority, vectored request/ack/return handshake and bus registers.
module interrupt_controller #(
  parameter int          NUM_IRQ       = 3,
  parameter logic [31:0] BASE_ADDR     = 32'h4000,
  parameter logic [31:0] VECTOR_BASE   = 32'h10,
  parameter logic [31:0] VECTOR_STRIDE = 32'h4,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_sources,
  input  logic               halt,
  input  logic [31:0]        slv_address,
  input  logic [31:0]        slv_write_data,
  input  logic [1:0]         slv_mode,
  input  logic               slv_select,
  output logic [31:0]        slv_read_data,
  output logic               irq_req,
  output logic [31:0]        irq_vector,
  input  logic               irq_ack,
  input  logic [31:0]        ret_pc,
  output logic [31:0]        ipc,
  input  logic               end_isr,
  output logic               in_isr
);
  localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
  logic [NUM_IRQ-1:0] s, prev, flags, mask, edge_mode, active_flag, pend, ev, w1c, frc, wdata;
  logic [IW-1:0] idx, active_irq;
  logic wr, rd, unused_wdata;
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_sources;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] sq [SYNC_STAGES];
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) sq[k] <= '1;
        end else begin
          sq[0] <= irq_sources;
          for (int k = 1; k < SYNC_STAGES; k++) sq[k] <= sq[k-1];
        end
      assign s = sq[SYNC_STAGES-1];
    end
  endgenerate
  assign wdata = slv_write_data[NUM_IRQ-1:0];
  assign unused_wdata = &{1'b0, slv_write_data};
  assign wr = slv_select && slv_mode == 2'b10;
  assign rd = slv_select && slv_mode == 2'b01;
  assign w1c = (wr && slv_address == BASE_ADDR + 32'h4) ? wdata : '0;
  assign frc = (wr && slv_address == BASE_ADDR + 32'h14) ? wdata : '0;
  // level sources fire while low; edge sources only on a high-to-low transition
  assign ev = halt ? '0 : ~s & ~(edge_mode & ~prev);
  assign pend = flags & mask;
  always_comb begin
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[i]) idx = IW'(i);
  end
  assign irq_req = |pend && !in_isr && !halt;
  assign irq_vector = irq_req ? VECTOR_BASE + 32'(idx) * VECTOR_STRIDE : VECTOR_BASE;
  assign slv_read_data = !rd                                   ? '0 :
                         slv_address == BASE_ADDR              ? 32'(mask) :
                         slv_address == BASE_ADDR + 32'h4      ? 32'(flags) :
                         slv_address == BASE_ADDR + 32'h8      ? 32'(active_irq) :
                         slv_address == BASE_ADDR + 32'hc      ? 32'(active_flag) :
                         slv_address == BASE_ADDR + 32'h10     ? 32'(edge_mode) : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mask        <= '0;
      flags       <= '0;
      edge_mode   <= '0;
      prev        <= '1;
      active_irq  <= '0;
      active_flag <= '0;
      ipc         <= '0;
      in_isr      <= 1'b0;
    end else begin
      flags <= (flags & ~w1c) | frc | ev;
      if (wr && slv_address == BASE_ADDR) mask <= wdata;
      if (wr && slv_address == BASE_ADDR + 32'h10) edge_mode <= wdata;
      if (!halt) begin
        prev <= s;
        if (end_isr && in_isr) in_isr <= 1'b0;
        else if (irq_ack && irq_req) begin
          in_isr      <= 1'b1;
          active_irq  <= idx;
          active_flag <= NUM_IRQ'(1) << idx;
          ipc         <= ret_pc;
        end
      end
    end
endmodule
